// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between instruction fetch and data access.
// One transaction is outstanding at a time, and requesters alternate when both are pending.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_re,
  input  logic [XLEN/8-1:0] i_sel,
  input  logic [XLEN-1:0]   i_addr,
  input  logic              i_abort,
  output logic              i_ack,
  output logic [31:0]       i_instr,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_sel,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_data_w,
  output logic              d_ack,
  output logic [XLEN-1:0]   d_data_r,
  output logic              mem_re,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_data_w,
  input  logic [XLEN-1:0]   mem_data_r,
  input  logic              mem_ack
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;
  state_t r_state;
  logic   r_last_d;
  logic   w_d_req, w_i_req, w_i_done, w_d_done, w_grant_d, w_grant_i;
  assign w_d_req  = d_re | d_we;
  assign w_i_req  = i_re & ~i_abort;
  assign w_i_done = mem_ack & (r_state == BUSY_I || r_state == DRAIN);
  assign w_d_done = mem_ack & (r_state == BUSY_D);
  // A completing requester only ever hands over to the other one, never to itself.
  assign w_grant_d = (r_state == IDLE) ? w_d_req & ~(r_last_d & w_i_req) : w_i_done & w_d_req;
  assign w_grant_i = (r_state == IDLE) ? w_i_req & ~w_grant_d : w_d_done & w_i_req;
  assign i_ack    = (r_state == BUSY_I) & mem_ack & ~i_abort;
  assign d_ack    = w_d_done;
  assign i_instr  = mem_data_r[31:0];
  assign d_data_r = mem_data_r;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= '0;
      mem_addr   <= '0;
      mem_data_w <= '0;
    end else begin
      if (w_grant_d) begin
        r_state    <= BUSY_D;
        mem_re     <= d_re;
        mem_we     <= d_we;
        mem_sel    <= d_sel;
        mem_addr   <= d_addr;
        mem_data_w <= d_data_w;
      end else if (w_grant_i) begin
        r_state  <= BUSY_I;
        mem_re   <= 1'b1;
        mem_we   <= 1'b0;
        mem_sel  <= i_sel;
        mem_addr <= i_addr;
      end else if (w_i_done | w_d_done) begin
        r_state <= IDLE;
        mem_re  <= 1'b0;
        mem_we  <= 1'b0;
      end else if (r_state == BUSY_I && i_abort) begin
        r_state <= DRAIN;
      end
      if (w_i_done | w_d_done) r_last_d <= w_d_done;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a scoreboard of expected downstream issues,
// popped by a monitor whenever a new transaction appears on the memory port.
module tb_mem_arbiter;
  logic        clk = 0, reset_n = 0;
  logic        i_re = 0, i_abort = 0, d_re = 0, d_we = 0, mem_ack = 0;
  logic [3:0]  i_sel = 4'hf, d_sel = 4'hf, mem_sel;
  logic [31:0] i_addr = 0, d_addr = 0, d_data_w = 0, mem_data_r = 0;
  logic        i_ack, d_ack, mem_re, mem_we;
  logic [31:0] i_instr, d_data_r, mem_addr, mem_data_w;
  int total = 0, bad = 0;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  txn_t exp_q[$];
  logic prev_active = 0, prev_ack = 0;

  mem_arbiter #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_re(i_re), .i_sel(i_sel), .i_addr(i_addr), .i_abort(i_abort), .i_ack(i_ack), .i_instr(i_instr),
    .d_re(d_re), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_data_w(d_data_w),
    .d_ack(d_ack), .d_data_r(d_data_r),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic we, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  always @(negedge clk) begin
    if ((mem_re | mem_we) && (!prev_active || prev_ack)) begin
      if (exp_q.size() == 0) chk("unexpected_issue", {32'h0, mem_addr}, 64'hffff_ffff);
      else begin
        txn_t t;
        t = exp_q.pop_front();
        chk("issue_addr", {32'h0, mem_addr}, {32'h0, t.addr});
        chk("issue_we", {63'h0, mem_we}, {63'h0, t.we});
        chk("issue_re", {63'h0, mem_re}, {63'h0, ~t.we});
        if (t.we) chk("issue_wdata", {32'h0, mem_data_w}, {32'h0, t.data});
      end
    end
    if (i_ack | d_ack) chk("ack_exclusive", {63'h0, i_ack & d_ack}, 64'h0);
    prev_active = mem_re | mem_we;
    prev_ack = mem_ack;
  end

  initial begin
    #2;
    chk("rst_re", {63'h0, mem_re}, 0);
    chk("rst_we", {63'h0, mem_we}, 0);
    chk("rst_addr", {32'h0, mem_addr}, 0);
    chk("rst_wdata", {32'h0, mem_data_w}, 0);
    chk("rst_sel", {60'h0, mem_sel}, 0);
    tick; tick;
    #3 reset_n = 1;
    tick;
    // data write
    d_we = 1; d_addr = 32'h40; d_data_w = 32'hdeadbeef; d_sel = 4'hf;
    expect_txn(1, 32'h40, 32'hdeadbeef);
    tick;
    chk("wr_mem_we", {63'h0, mem_we}, 1);
    chk("wr_mem_re", {63'h0, mem_re}, 0);
    chk("wr_sel", {60'h0, mem_sel}, 64'hf);
    tick;
    mem_ack = 1; #1;
    chk("wr_d_ack", {63'h0, d_ack}, 1);
    chk("wr_i_ack", {63'h0, i_ack}, 0);
    d_we = 0;
    tick; mem_ack = 0;
    chk("wr_done_we", {63'h0, mem_we}, 0);
    // lone fetch
    i_re = 1; i_addr = 32'h100;
    expect_txn(0, 32'h100, 0);
    tick;
    chk("lf_re", {63'h0, mem_re}, 1);
    chk("lf_addr", {32'h0, mem_addr}, 64'h100);
    tick; #1;
    chk("lf_no_early_ack", {63'h0, i_ack}, 0);
    tick;
    mem_ack = 1; mem_data_r = 32'h00000013; #1;
    chk("lf_i_ack", {63'h0, i_ack}, 1);
    chk("lf_instr", {32'h0, i_instr}, 64'h13);
    chk("lf_d_ack", {63'h0, d_ack}, 0);
    i_re = 0;
    tick; mem_ack = 0;
    chk("lf_done_re", {63'h0, mem_re}, 0);
    // contention: D, I, D with no bubbles
    i_re = 1; i_addr = 32'h104; d_re = 1; d_addr = 32'h2000;
    expect_txn(0, 32'h2000, 0);
    expect_txn(0, 32'h104, 0);
    expect_txn(0, 32'h2004, 0);
    tick;
    chk("ct_first_d", {32'h0, mem_addr}, 64'h2000);
    tick; tick;
    mem_ack = 1; mem_data_r = 32'hd1; #1;
    chk("ct_d_ack", {63'h0, d_ack}, 1);
    chk("ct_d_data", {32'h0, d_data_r}, 64'hd1);
    chk("ct_i_ack0", {63'h0, i_ack}, 0);
    d_addr = 32'h2004;
    tick; mem_ack = 0;
    chk("ct_i_nobubble", {63'h0, mem_re}, 1);
    chk("ct_i_addr", {32'h0, mem_addr}, 64'h104);
    tick; tick;
    mem_ack = 1; mem_data_r = 32'h1234_5678; #1;
    chk("ct_i_ack", {63'h0, i_ack}, 1);
    chk("ct_i_instr", {32'h0, i_instr}, 64'h1234_5678);
    chk("ct_d_ack0", {63'h0, d_ack}, 0);
    i_re = 0;
    tick; mem_ack = 0;
    chk("ct_d2_addr", {32'h0, mem_addr}, 64'h2004);
    tick; tick;
    mem_ack = 1; #1;
    chk("ct_d2_ack", {63'h0, d_ack}, 1);
    d_re = 0;
    tick; mem_ack = 0;
    chk("ct_idle", {63'h0, mem_re}, 0);
    // abort with drain
    i_re = 1; i_addr = 32'h200;
    expect_txn(0, 32'h200, 0);
    tick;
    chk("ab_issue", {63'h0, mem_re}, 1);
    i_abort = 1; i_re = 0;
    tick; i_abort = 0;
    chk("ab_drain_re", {63'h0, mem_re}, 1);
    tick;
    mem_ack = 1; #1;
    chk("ab_i_ack", {63'h0, i_ack}, 0);
    chk("ab_d_ack", {63'h0, d_ack}, 0);
    tick; mem_ack = 0;
    chk("ab_idle", {63'h0, mem_re}, 0);
    i_re = 1; i_addr = 32'h300;
    expect_txn(0, 32'h300, 0);
    tick;
    chk("ab_new_fetch", {32'h0, mem_addr}, 64'h300);
    // abort coincident with ack
    tick;
    mem_ack = 1; i_abort = 1; #1;
    chk("aa_i_ack", {63'h0, i_ack}, 0);
    i_re = 0;
    tick; mem_ack = 0; i_abort = 0;
    chk("aa_no_drain", {63'h0, mem_re}, 0);
    d_re = 1; d_addr = 32'h50;
    expect_txn(0, 32'h50, 0);
    tick;
    chk("aa_next_grant", {32'h0, mem_addr}, 64'h50);
    // reset mid BUSY_D
    tick;
    reset_n = 0; d_re = 0; #1;
    chk("rs_re", {63'h0, mem_re}, 0);
    chk("rs_addr", {32'h0, mem_addr}, 0);
    tick;
    reset_n = 1;
    mem_ack = 1; #1;
    chk("rs_stray_d_ack", {63'h0, d_ack}, 0);
    chk("rs_stray_i_ack", {63'h0, i_ack}, 0);
    tick; mem_ack = 0;
    chk("rs_still_idle", {63'h0, mem_re | mem_we}, 0);
    tick;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
